axis_congestion_monitor: RTL

Consumes the windowed-average counters produced by the AXIS bandwidth-usage block: valid-up, ready-up and both-up counts per window. Derives a backpressure (stall) metric and a starvation (idle) metric from them. A hysteresis/dwell state machine raises a debounced congestion flag toward the RoCE transmit rate control. Also keeps a peak-stall register and a saturating congestion-event counter for status readout.

---
 rtl/axis_congestion_monitor_pkg.sv | 17 +
 rtl/hyst_dwell_fsm.sv | 80 ++++++++
 rtl/axis_congestion_monitor.sv | 76 +++++++
 3 files changed

// File: rtl/axis_congestion_monitor_pkg.sv
// Shared definitions for the AXIS congestion monitor: FSM state codes,
// the default dwell length and a saturating subtract helper.
package axis_congestion_monitor_pkg;

  localparam logic [1:0] ST_NORMAL     = 2'd0;
  localparam logic [1:0] ST_PEND_CONG  = 2'd1;
  localparam logic [1:0] ST_CONGESTED  = 2'd2;
  localparam logic [1:0] ST_PEND_CLEAR = 2'd3;

  localparam int DEF_DWELL_CYCLES = 4;

  // a - b, floored at zero; operands up to 32 bits wide
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : 32'd0;
  endfunction

endpackage

// File: rtl/hyst_dwell_fsm.sv
// Generic two-threshold dwell state machine: a condition must hold for
// DWELL_CYCLES consecutive evaluations before the active flag changes.
module hyst_dwell_fsm
  import axis_congestion_monitor_pkg::*;
#(
  parameter int DWELL_CYCLES = DEF_DWELL_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_c,
  input  logic       clr_c,
  output logic [1:0] state,
  output logic       active,
  output logic       enter,
  output logic       rise
);

  localparam logic [15:0] LAST = 16'(DWELL_CYCLES - 1);

  logic [1:0]  nxt_state;
  logic [15:0] dwell, nxt_dwell;

  always_comb begin
    nxt_state = state;
    nxt_dwell = dwell;
    case (state)
      ST_NORMAL:
        if (set_c) begin
          if (DWELL_CYCLES == 1) nxt_state = ST_CONGESTED;
          else begin
            nxt_state = ST_PEND_CONG;
            nxt_dwell = 16'd1;
          end
        end
      ST_PEND_CONG:
        if (!set_c) begin
          nxt_state = ST_NORMAL;
          nxt_dwell = 16'd0;
        end else if (dwell == LAST) begin
          nxt_state = ST_CONGESTED;
          nxt_dwell = 16'd0;
        end else nxt_dwell = dwell + 16'd1;
      ST_CONGESTED:
        if (clr_c) begin
          if (DWELL_CYCLES == 1) nxt_state = ST_NORMAL;
          else begin
            nxt_state = ST_PEND_CLEAR;
            nxt_dwell = 16'd1;
          end
        end
      default: // ST_PEND_CLEAR
        if (!clr_c) begin
          nxt_state = ST_CONGESTED;
          nxt_dwell = 16'd0;
        end else if (dwell == LAST) begin
          nxt_state = ST_NORMAL;
          nxt_dwell = 16'd0;
        end else nxt_dwell = dwell + 16'd1;
    endcase
  end

  // Only a fresh entry counts; falling back from PEND_CLEAR is not an entry
  assign enter = (nxt_state == ST_CONGESTED) &&
                 ((state == ST_NORMAL) || (state == ST_PEND_CONG));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_NORMAL;
      dwell  <= 16'd0;
      active <= 1'b0;
      rise   <= 1'b0;
    end else begin
      state  <= nxt_state;
      dwell  <= nxt_dwell;
      active <= (nxt_state == ST_CONGESTED) || (nxt_state == ST_PEND_CLEAR);
      rise   <= enter;
    end
  end

endmodule

// File: rtl/axis_congestion_monitor.sv
// Turns windowed AXIS valid/ready/both counts into stall and idle metrics,
// debounces a congestion flag and keeps peak-stall / event statistics.
module axis_congestion_monitor
  import axis_congestion_monitor_pkg::*;
#(
  parameter int WINDOW_WIDTH  = 16,
  parameter int DWELL_CYCLES  = DEF_DWELL_CYCLES,
  parameter int EVT_CTR_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WINDOW_WIDTH-1:0]  n_valid_up,
  input  logic [WINDOW_WIDTH-1:0]  n_ready_up,
  input  logic [WINDOW_WIDTH-1:0]  n_both_up,
  input  logic [WINDOW_WIDTH-1:0]  cong_on_thresh,
  input  logic [WINDOW_WIDTH-1:0]  cong_off_thresh,
  input  logic [WINDOW_WIDTH-1:0]  starve_thresh,
  input  logic                     clear_stats,
  output logic                     congested,
  output logic                     cong_start,
  output logic                     starved,
  output logic [WINDOW_WIDTH-1:0]  stall_up,
  output logic [WINDOW_WIDTH-1:0]  peak_stall,
  output logic [EVT_CTR_WIDTH-1:0] cong_events,
  output logic [1:0]               state
);

  localparam logic [EVT_CTR_WIDTH-1:0] EVT_MAX = '1;

  logic [WINDOW_WIDTH-1:0] stall_c, idle_c, eff_off;
  logic                    on_c, off_c, enter;

  // sat_sub works on 32-bit operands, so WINDOW_WIDTH is limited to 32
  assign stall_c = WINDOW_WIDTH'(sat_sub(32'(n_valid_up), 32'(n_both_up)));
  assign idle_c  = WINDOW_WIDTH'(sat_sub(32'(n_ready_up), 32'(n_both_up)));

  // An off threshold above the on threshold collapses to no hysteresis
  assign eff_off = (cong_off_thresh < cong_on_thresh) ? cong_off_thresh : cong_on_thresh;
  assign on_c    = (stall_up >= cong_on_thresh);
  assign off_c   = (stall_up <= eff_off);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_up <= '0;
      starved  <= 1'b0;
    end else begin
      stall_up <= stall_c;
      starved  <= (idle_c >= starve_thresh);
    end
  end

  hyst_dwell_fsm #(.DWELL_CYCLES(DWELL_CYCLES)) u_fsm (
    .clk    (clk),
    .rst    (rst),
    .set_c  (on_c),
    .clr_c  (off_c),
    .state  (state),
    .active (congested),
    .enter  (enter),
    .rise   (cong_start)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_stall  <= '0;
      cong_events <= '0;
    end else if (clear_stats) begin
      peak_stall  <= '0;
      cong_events <= enter ? EVT_CTR_WIDTH'(1) : '0;
    end else begin
      if (stall_up > peak_stall) peak_stall <= stall_up;
      if (enter && (cong_events != EVT_MAX)) cong_events <= cong_events + 1'b1;
    end
  end

endmodule
